// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the operand-B source classification
// used by the operand fetch stage.
package mips_pkg;

    // Primary opcodes (ins[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'd0;
    localparam logic [5:0] OPC_BEQ   = 6'd4;
    localparam logic [5:0] OPC_BNE   = 6'd5;
    localparam logic [5:0] OPC_ADDI  = 6'd8;
    localparam logic [5:0] OPC_ADDIU = 6'd9;
    localparam logic [5:0] OPC_SLTI  = 6'd10;
    localparam logic [5:0] OPC_SLTIU = 6'd11;
    localparam logic [5:0] OPC_ANDI  = 6'd12;
    localparam logic [5:0] OPC_ORI   = 6'd13;
    localparam logic [5:0] OPC_XORI  = 6'd14;
    localparam logic [5:0] OPC_LW    = 6'd35;
    localparam logic [5:0] OPC_SW    = 6'd43;

    // R-type function codes (ins[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Where the second source operand comes from
    typedef enum logic [1:0] {
        REG  = 2'd0,  // GPR[rt]
        SEXT = 2'd1,  // sign-extended imm16
        ZEXT = 2'd2,  // zero-extended imm16
        NONE = 2'd3   // unsupported opcode: both operands forced to zero
    } src2_kind_e;

    // Classify an opcode by its second-operand source
    function automatic src2_kind_e src2_kind(input logic [5:0] opc);
        src2_kind_e k;
        case (opc)
            OPC_RTYPE, OPC_BEQ, OPC_BNE:                    k = REG;
            OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU,
            OPC_LW, OPC_SW:                                 k = SEXT;
            OPC_ANDI, OPC_ORI, OPC_XORI:                    k = ZEXT;
            default:                                        k = NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 general register file: two combinational read ports, one
// synchronous write port, register 0 hardwired to zero.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra_addr,
    output logic [31:0] ra_data,
    input  logic [4:0]  rb_addr,
    output logic [31:0] rb_data,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs [32];

    // Clear everything on reset; otherwise write any register except $0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // $0 reads as zero regardless of array contents
    assign ra_data = (ra_addr == 5'd0) ? 32'd0 : regs[ra_addr];
    assign rb_data = (rb_addr == 5'd0) ? 32'd0 : regs[rb_addr];

endmodule

// File: rtl/mips_operand_fetch.sv
// MIPS operand fetch stage: decodes the source operands of an instruction,
// reads the register file and registers a {ins, regA, regB} bundle for the
// ALU behind a one-deep valid/ready output register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and an offered bundle stays
// stable until it is taken.
//
// Build option: define OPFETCH_WB_BYPASS_EN to forward a same-cycle
// write-back into the captured operands instead of stalling the input.
module mips_operand_fetch
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_ins,
    output logic        in_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_regA,
    output logic [31:0] out_regB,
    output logic [31:0] issue_cnt
);

    logic [4:0]  rs;
    logic [4:0]  rt;
    src2_kind_e  kind;
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        wb_live;
    logic        hit_rs;
    logic        hit_rt;
    logic        stall;
    logic        accept;
    logic        fire;

    assign rs   = in_ins[25:21];
    assign rt   = in_ins[20:16];
    assign kind = src2_kind(in_ins[31:26]);

    mips_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (rs),
        .ra_data (rf_a),
        .rb_addr (rt),
        .rb_data (rf_b),
        .we      (wb_en),
        .wa      (wb_addr),
        .wd      (wb_data)
    );

    // A write this cycle collides with a source the instruction actually reads
    assign wb_live = wb_en && (wb_addr != 5'd0);
    assign hit_rs  = wb_live && (wb_addr == rs);
    assign hit_rt  = wb_live && (kind == REG) && (wb_addr == rt);

`ifdef OPFETCH_WB_BYPASS_EN
    assign stall  = 1'b0;
    assign rs_val = hit_rs ? wb_data : rf_a;
    assign rt_val = hit_rt ? wb_data : rf_b;
`else
    // Hold the instruction off one cycle so it reads the committed value
    assign stall  = hit_rs || hit_rt;
    assign rs_val = rf_a;
    assign rt_val = rf_b;
`endif

    // Select the second source by opcode class; unsupported opcodes read zeros
    always_comb begin
        src1 = rs_val;
        src2 = rt_val;
        case (kind)
            SEXT: src2 = {{16{in_ins[15]}}, in_ins[15:0]};
            ZEXT: src2 = {16'd0, in_ins[15:0]};
            NONE: begin
                src1 = '0;
                src2 = '0;
            end
            default: ;
        endcase
    end

    // ALU port contract: operands swap whenever the rs field is nonzero
    assign opa = (rs == 5'd0) ? src1 : src2;
    assign opb = (rs == 5'd0) ? src2 : src1;

    assign in_ready = !rst && (!out_valid || out_ready) && !stall;
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;

    // Output bundle register and handshake counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ins   <= '0;
            out_regA  <= '0;
            out_regB  <= '0;
            issue_cnt <= '0;
        end else begin
            if (fire) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_ins   <= in_ins;
                out_regA  <= opa;
                out_regB  <= opb;
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_operand_fetch.sv
// Directed testbench for mips_operand_fetch. Expected operand bundles are
// hand-computed and queued; a negedge monitor pops one per output handshake.
module tb_mips_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_ins;
    logic        in_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_regA;
    logic [31:0] out_regB;
    logic [31:0] issue_cnt;

    int          checks    = 0;
    int          failures  = 0;
    int          exp_issue = 0;
    logic [95:0] exp_q [$];
    logic [95:0] mon_e;
    logic [31:0] stream [5];

    mips_operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ins    (in_ins),
        .in_ready  (in_ready),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ins   (out_ins),
        .out_regA  (out_regA),
        .out_regB  (out_regB),
        .issue_cnt (issue_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        cycle();
        wb_en   = 1'b0;
    endtask

    // Present one instruction with out_ready high, expect the bundle next cycle
    task automatic issue(input string tag, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        in_valid  = 1'b1;
        in_ins    = ins;
        out_ready = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 8) begin
            cycle();
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
        if (in_ready) exp_q.push_back({ins, a, b});
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_latency"}, {31'd0, out_valid}, 32'd1);
        cycle();
        exp_issue++;
    endtask

    // Scoreboard: every output handshake must match the oldest expected bundle
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_bundle", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_ins",  out_ins,  mon_e[95:64]);
                check("sb_regA", out_regA, mon_e[63:32]);
                check("sb_regB", out_regB, mon_e[31:0]);
            end
        end
    end

    initial begin
        stream[0] = 32'h01095020;
        stream[1] = 32'h01095820;
        stream[2] = 32'h01096020;
        stream[3] = 32'h01096820;
        stream[4] = 32'h01097020;

        rst = 1'b1; in_valid = 1'b0; in_ins = '0; out_ready = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        cycle();
        cycle();

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_issue_cnt", issue_cnt, 32'd0);
        check("rst_out_ins",   out_ins,   32'd0);
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check("first_cycle_ready", {31'd0, in_ready}, 32'd1);
        cycle();

        // Operand selection and port mapping
        wb_write(5'd8, 32'd5);
        wb_write(5'd9, 32'd7);
        issue("add",   32'h01095020, 32'd7, 32'd5);
        wb_write(5'd8, 32'h10);
        issue("addi",  32'h2109FFFF, 32'hFFFFFFFF, 32'h10);
        issue("ori",   32'h3509FFFF, 32'h0000FFFF, 32'h10);
        issue("addiu_rs0", 32'h24010005, 32'd0, 32'd5);
        issue("beq",   32'h11090003, 32'd7, 32'h10);
        issue("sra_rs0", 32'h00090883, 32'd0, 32'd7);
        issue("unsupported", 32'h3D091234, 32'd0, 32'd0);
        @(negedge clk);
        check("issue_cnt_after_basic", issue_cnt, exp_issue);
        cycle();

        // Write-back hazard on rs
        wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
        in_valid = 1'b1; in_ins = 32'h01095020; out_ready = 1'b1;
        @(negedge clk);
`ifdef OPFETCH_WB_BYPASS_EN
        check("haz_bypass_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back({32'h01095020, 32'd7, 32'h1234});
        cycle();
        wb_en = 1'b0;
        in_valid = 1'b0;
`else
        check("haz_stall", {31'd0, in_ready}, 32'd0);
        cycle();
        wb_en = 1'b0;
        @(negedge clk);
        check("haz_accept_after_stall", {31'd0, in_ready}, 32'd1);
        exp_q.push_back({32'h01095020, 32'd7, 32'h1234});
        cycle();
        in_valid = 1'b0;
`endif
        @(negedge clk);
        check("haz_latency", {31'd0, out_valid}, 32'd1);
        cycle();
        exp_issue++;

        // A write to rt of an immediate-form instruction is not a hazard
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'd7;
        in_valid = 1'b1; in_ins = 32'h2109FFFF;
        @(negedge clk);
        check("imm_rt_no_stall", {31'd0, in_ready}, 32'd1);
        exp_q.push_back({32'h2109FFFF, 32'hFFFFFFFF, 32'h1234});
        cycle();
        wb_en = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("imm_rt_latency", {31'd0, out_valid}, 32'd1);
        cycle();
        exp_issue++;

        // Back-pressure: hold for 3 cycles, then stream 4 back-to-back
        in_valid = 1'b1; in_ins = stream[0]; out_ready = 1'b0;
        @(negedge clk);
        check("bp_accept0", {31'd0, in_ready}, 32'd1);
        exp_q.push_back({stream[0], 32'd7, 32'h1234});
        cycle();
        in_ins = stream[1];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, in_ready},  32'd0);
            check("bp_hold_ins",   out_ins,  stream[0]);
            check("bp_hold_regA",  out_regA, 32'd7);
            check("bp_hold_regB",  out_regB, 32'h1234);
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_ins = stream[k+1];
            @(negedge clk);
            check("bp_stream_ready", {31'd0, in_ready}, 32'd1);
            exp_q.push_back({stream[k+1], 32'd7, 32'h1234});
            cycle();
            exp_issue++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_issue_cnt_plus4", issue_cnt, exp_issue);
        check("bp_last_valid", {31'd0, out_valid}, 32'd1);
        cycle();
        exp_issue++;
        @(negedge clk);
        check("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        check("bp_drain_cnt", issue_cnt, exp_issue);
        cycle();

        // Reset with a bundle in flight; write-back during reset is ignored
        in_valid = 1'b1; in_ins = 32'h01095020; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        cycle();
        rst = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
        cycle();
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_issue_cnt", issue_cnt, 32'd0);
        check("mid_rst_out_regA",  out_regA,  32'd0);
        check("mid_rst_in_ready",  {31'd0, in_ready}, 32'd0);
        cycle();
        rst = 1'b0;
        wb_en = 1'b0;
        exp_issue = 0;
        check("queue_empty_at_rst", exp_q.size(), 32'd0);

        wb_write(5'd0, 32'hDEADBEEF);
        issue("post_rst_gprs", 32'h01095020, 32'd0, 32'd0);
        issue("gpr0_reads_zero", 32'h00000820, 32'd0, 32'd0);
        @(negedge clk);
        check("post_rst_issue_cnt", issue_cnt, exp_issue);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
